// File: rtl/pc_gen_if.sv
// Fetch-side bundle between the PC generator and instruction memory.
// Carries redirect, stall and handshake signals plus the fetch address.
interface pc_gen_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  stall;
  logic                  br_valid;
  logic [ADDR_WIDTH-1:0] br_target;
  logic                  exc_valid;
  logic [ADDR_WIDTH-1:0] exc_target;
  logic                  fetch_ack;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  chip_enable;
  logic                  misalign_err;

  modport master (
    input  stall,
    input  br_valid,
    input  br_target,
    input  exc_valid,
    input  exc_target,
    input  fetch_ack,
    output pc,
    output chip_enable,
    output misalign_err
  );

  modport slave (
    output stall,
    output br_valid,
    output br_target,
    output exc_valid,
    output exc_target,
    output fetch_ack,
    input  pc,
    input  chip_enable,
    input  misalign_err
  );
endinterface

// File: rtl/pc_gen.sv
// Program counter generator: sequential fetch with branch/exception redirect.
// Optional macro PC_ALIGN_CHECK_EN rejects misaligned redirect targets.
module pc_gen #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INST_BYTES   = 4
) (
  input  logic     clk,
  input  logic     rst,
  pc_gen_if.master bus
);
  localparam logic [ADDR_WIDTH-1:0] STEP =
    ADDR_WIDTH'(INST_BYTES);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'(INST_BYTES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state;
  state_t                state_nx;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] pc_nx;
  logic [ADDR_WIDTH-1:0] tgt;
  logic                  redir;
  logic                  bad;
  logic                  ce_q;
  logic                  ce_nx;

  // State register
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next state: IDLE leaves on the first edge out of reset
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = RUN;
      RUN:  state_nx = RUN;
    endcase
  end

  // Redirect select: exception beats branch
  always_comb begin
    redir = bus.exc_valid | bus.br_valid;
    tgt   = bus.exc_valid ? bus.exc_target
                          : bus.br_target;
`ifdef PC_ALIGN_CHECK_EN
    bad   = redir && ((tgt & AMASK) != '0);
`else
    bad   = 1'b0;
`endif
  end

  // Next PC and registered request strobe
  always_comb begin
    pc_nx = pc_q;
    ce_nx = !bus.stall;
    if (state == RUN) begin
      if (redir) begin
        if (!bad) pc_nx = tgt;
      end else if (ce_q && bus.fetch_ack
                   && !bus.stall) begin
        pc_nx = pc_q + STEP;
      end
    end
  end

  // PC and strobe registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q <= RESET_VECTOR;
      ce_q <= 1'b0;
    end else begin
      pc_q <= pc_nx;
      ce_q <= ce_nx;
    end
  end

`ifdef PC_ALIGN_CHECK_EN
  logic err_q;

  // One-cycle error pulse per rejected redirect
  always_ff @(posedge clk) begin
    if (!rst) err_q <= 1'b0;
    else      err_q <= (state == RUN) && bad;
  end
`endif

  // Outputs
  always_comb begin
    bus.pc          = pc_q;
    bus.chip_enable = (state == RUN) && ce_q;
`ifdef PC_ALIGN_CHECK_EN
    bus.misalign_err = err_q;
`else
    bus.misalign_err = 1'b0;
`endif
  end
endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed cases then random traffic.
// A second 8-bit instance exercises address wraparound.
module tb_pc_gen;
  localparam int IB = 4;
  localparam longint unsigned RV8 = 64'hF0;
`ifdef PC_ALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    bit              run;
    bit              ce;
    bit              err;
    longint unsigned pc;
  } mdl_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  mdl_t m;
  mdl_t m8;

  pc_gen_if #(.ADDR_WIDTH(32)) bus ();
  pc_gen_if #(.ADDR_WIDTH(8))  bus8 ();

  pc_gen #(
    .ADDR_WIDTH(32),
    .RESET_VECTOR(32'h0),
    .INST_BYTES(IB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  pc_gen #(
    .ADDR_WIDTH(8),
    .RESET_VECTOR(8'hF0),
    .INST_BYTES(IB)
  ) dut8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t advance(
    input mdl_t            s,
    input bit              r,
    input bit              stl,
    input bit              ack,
    input bit              bv,
    input longint unsigned bt,
    input bit              ev,
    input longint unsigned et,
    input int              w,
    input longint unsigned rv
  );
    mdl_t            n;
    longint unsigned lim;
    longint unsigned t;
    lim = 64'd1 << w;
    n = s;
    if (!r) begin
      n.run = 0; n.ce = 0; n.err = 0; n.pc = rv;
      return n;
    end
    n.err = 0;
    n.ce  = !stl;
    if (!s.run) begin
      n.run = 1;
      return n;
    end
    if (ev || bv) begin
      t = ev ? et : bt;
      if (CHK && (t % IB) != 0) n.err = 1;
      else                      n.pc  = t;
    end else if (s.ce && ack && !stl) begin
      n.pc = (s.pc + IB) % lim;
    end
    return n;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    m = advance(m, rst, bus.stall, bus.fetch_ack,
                bus.br_valid, 64'(bus.br_target),
                bus.exc_valid, 64'(bus.exc_target),
                32, 64'h0);
    m8 = advance(m8, rst, 1'b0, 1'b1, 1'b0, 64'h0,
                 1'b0, 64'h0, 8, RV8);
    #1;
    check("pc", bus.pc, m.pc[31:0]);
    check("ce", {31'b0, bus.chip_enable},
          {31'b0, m.run && m.ce});
    check("err", {31'b0, bus.misalign_err},
          {31'b0, m.err});
    check("pc8", {24'b0, bus8.pc}, m8.pc[31:0]);
    check("err8", {31'b0, bus8.misalign_err}, 32'h0);
  endtask

  task automatic redir(input bit ev, input bit bv,
                       input logic [31:0] et,
                       input logic [31:0] bt);
    bus.exc_valid  = ev;
    bus.exc_target = et;
    bus.br_valid   = bv;
    bus.br_target  = bt;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m  = '{run: 0, ce: 0, err: 0, pc: 0};
    m8 = '{run: 0, ce: 0, err: 0, pc: RV8};
    rst = 1'b0;
    bus.stall = 1'b0;
    bus.fetch_ack = 1'b0;
    redir(0, 0, 32'h0, 32'h0);
    bus8.stall = 1'b0;
    bus8.fetch_ack = 1'b1;
    bus8.br_valid = 1'b0;
    bus8.br_target = 8'h0;
    bus8.exc_valid = 1'b0;
    bus8.exc_target = 8'h0;

    // reset state
    step();
    step();
    check("rst_pc", bus.pc, 32'h0);
    check("rst_ce", {31'b0, bus.chip_enable}, 32'h0);
    check("rst_pc8", {24'b0, bus8.pc}, 32'hF0);

    // reset release, sequential fetch
    rst = 1'b1;
    bus.fetch_ack = 1'b1;
    redir(1, 1, 32'h80, 32'h90);
    step();
    check("run_ce", {31'b0, bus.chip_enable}, 32'h1);
    check("run_pc0", bus.pc, 32'h0);
    redir(0, 0, 32'h0, 32'h0);
    step(); check("seq_4", bus.pc, 32'h4);
    step(); check("seq_8", bus.pc, 32'h8);
    step(); check("seq_c", bus.pc, 32'hC);
    step(); check("seq_10", bus.pc, 32'h10);

    // held request
    bus.fetch_ack = 1'b0;
    repeat (3) step();
    check("hold_10", bus.pc, 32'h10);
    bus.fetch_ack = 1'b1;
    step(); check("ack_14", bus.pc, 32'h14);

    // exception beats branch
    redir(1, 1, 32'h200, 32'h100);
    step(); check("exc_wins", bus.pc, 32'h200);
    redir(0, 0, 32'h0, 32'h0);
    bus.fetch_ack = 1'b0;
    step(); check("exc_hold", bus.pc, 32'h200);

    // misaligned branch
    redir(0, 1, 32'h0, 32'h102);
    step();
    check("mis_pc", bus.pc, CHK ? 32'h200 : 32'h102);
    check("mis_err", {31'b0, bus.misalign_err},
          {31'b0, CHK});
    redir(0, 0, 32'h0, 32'h0);
    step();
    check("mis_pulse", {31'b0, bus.misalign_err}, 32'h0);

    // 32-bit wrap
    redir(0, 1, 32'h0, 32'hFFFF_FFFC);
    step(); check("wrap_pre", bus.pc, 32'hFFFF_FFFC);
    redir(0, 0, 32'h0, 32'h0);
    bus.fetch_ack = 1'b1;
    step(); check("wrap_0", bus.pc, 32'h0);
    check("wrap_err", {31'b0, bus.misalign_err}, 32'h0);

    // stall freezes advance, strobe lags by a cycle
    bus.stall = 1'b1;
    step();
    check("stall_pc", bus.pc, 32'h0);
    check("stall_ce", {31'b0, bus.chip_enable}, 32'h0);
    redir(0, 1, 32'h0, 32'h40);
    step(); check("stall_redir", bus.pc, 32'h40);
    redir(0, 0, 32'h0, 32'h0);
    bus.stall = 1'b0;
    step();
    step(); check("resume", bus.pc, 32'h44);

    // reset with stall and outstanding request
    bus.fetch_ack = 1'b0;
    step();
    bus.stall = 1'b1;
    rst = 1'b0;
    redir(1, 1, 32'h300, 32'h400);
    step();
    check("mid_rst_pc", bus.pc, 32'h0);
    check("mid_rst_ce", {31'b0, bus.chip_enable}, 32'h0);
    rst = 1'b1;
    bus.stall = 1'b0;
    redir(0, 0, 32'h0, 32'h0);
    step();
    check("rerun_ce", {31'b0, bus.chip_enable}, 32'h1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst           = ($urandom_range(99) >= 2);
      bus.stall     = ($urandom_range(3) == 0);
      bus.fetch_ack = ($urandom_range(9) < 6);
      bus.br_valid  = ($urandom_range(9) == 0);
      bus.exc_valid = ($urandom_range(19) == 0);
      bus.br_target = $urandom;
      bus.exc_target = $urandom;
      if ($urandom_range(7) != 0)
        bus.br_target[1:0] = 2'b00;
      if ($urandom_range(7) != 0)
        bus.exc_target[1:0] = 2'b00;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, SHALL set the PC and target width in bits.
REQ-002 Parameter RESET_VECTOR, default 0, SHALL set the PC value loaded on reset.
REQ-003 Parameter INST_BYTES, default 4, SHALL set the sequential step; legal values are 1, 2, 4 and 8.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: synchronous, active-low (0 = reset).
REQ-006 stall  in  1  SHALL, when 1, freeze sequential PC advance.
REQ-007 br_valid  in  1  SHALL, when 1, request a branch redirect.
REQ-008 br_target  in  ADDR_WIDTH  SHALL carry the branch target.
REQ-009 exc_valid  in  1  SHALL, when 1, request an exception redirect.
REQ-010 exc_target  in  ADDR_WIDTH  SHALL carry the exception target.
REQ-011 fetch_ack  in  1  SHALL indicate that instruction memory accepted the current request.
REQ-012 pc  out  ADDR_WIDTH  SHALL carry the fetch address.
REQ-013 chip_enable  out  1  SHALL be the fetch request strobe to instruction memory.
REQ-014 misalign_err  out  1  SHALL be the misaligned-redirect error pulse.

Function
REQ-015 FSM states SHALL be IDLE and RUN.
REQ-016 IDLE SHALL hold chip_enable=0 and pc=RESET_VECTOR, and SHALL go to RUN on the first clock edge with rst=1.
REQ-017 In RUN, chip_enable SHALL equal !stall, registered one cycle after the stall change.
REQ-018 Request handshake: pc SHALL stay stable while chip_enable=1 and fetch_ack=0.
REQ-019 If chip_enable=1, fetch_ack=1 and stall=0 on an edge, pc SHALL become pc+INST_BYTES on that edge.
REQ-020 Sequential add SHALL wrap modulo 2^ADDR_WIDTH, with no carry out and no error.
REQ-021 Next-PC priority SHALL be: exc_valid, then br_valid, then sequential advance, then hold.
REQ-022 A redirect SHALL load its target on the same edge, regardless of fetch_ack or stall, and SHALL cancel any unacked request.
REQ-023 After a redirect, the next request SHALL carry the target; redirect latency is 1 cycle.
REQ-024 If exc_valid and br_valid are both 1, br_target SHALL be discarded.
REQ-025 stall=1 with no redirect SHALL hold pc; stall SHALL NOT block redirects.
REQ-026 Redirect inputs in IDLE SHALL be ignored.

Reset
REQ-027 rst=0 sampled on a rising edge SHALL set pc=RESET_VECTOR, chip_enable=0, misalign_err=0 and state=IDLE.
REQ-028 Reset mid-operation (outstanding request, concurrent redirect or stall) SHALL override all inputs.
REQ-029 On the first cycle in RUN after reset release, chip_enable SHALL be 1 with pc=RESET_VECTOR, if stall=0.

Configuration
REQ-030 With macro PC_ALIGN_CHECK_EN defined, a winning redirect target whose low log2(INST_BYTES) bits are nonzero SHALL NOT be loaded.
- pc SHALL hold.
- misalign_err SHALL pulse 1 for exactly one cycle.
- An unacked request SHALL remain outstanding.
REQ-031 Without PC_ALIGN_CHECK_EN, targets SHALL be loaded unmodified and misalign_err SHALL be tied 0.

Verification
REQ-032 Reset release, stall=0, fetch_ack=1 every cycle -> chip_enable rises 1 cycle after release; pc sequence is 0x0, 0x4, 0x8, 0xC.
REQ-033 pc=0x10, fetch_ack held 0 for 3 cycles then 1 -> pc stays 0x10 for 4 cycles, then 0x14.
REQ-034 Same cycle: br_valid=1 with br_target=0x100, exc_valid=1 with exc_target=0x200 -> next pc=0x200; 0x100 never appears.
REQ-035 ADDR_WIDTH=8, pc=0xFC, ack -> pc=0x00; misalign_err stays 0.
REQ-036 PC_ALIGN_CHECK_EN defined, br_target=0x102 -> pc holds, misalign_err=1 for 1 cycle. Undefined -> pc=0x102.
REQ-037 rst=0 asserted while stall=1 with a request outstanding -> next cycle pc=RESET_VECTOR, chip_enable=0.
